// File: rtl/scarv_cop_palu_issue_pkg.sv
// Shared definitions for the PALU issue block: instruction class codes, FSM encodings
// and the packed instruction-queue entry.
package scarv_cop_palu_issue_pkg;

   localparam logic [2:0] CLASS_PACKED_ARITH = 3'd1;
   localparam logic [2:0] CLASS_TWIDDLE      = 3'd2;
   localparam logic [2:0] CLASS_BITWISE      = 3'd4;
   localparam logic [2:0] CLASS_CMOV         = 3'd6;

   localparam logic [3:0] SUBCLASS_PADD      = 4'd0;
   localparam logic [3:0] SUBCLASS_PSUB      = 4'd1;
   localparam logic [3:0] SUBCLASS_PMUL      = 4'd3;
   localparam logic [3:0] SUBCLASS_CMOV_T    = 4'd0;

   localparam logic [2:0] PW_32              = 3'd0;
   localparam logic [2:0] PW_16              = 3'd1;

   localparam logic [1:0] ST_IDLE            = 2'd0;
   localparam logic [1:0] ST_EXEC            = 2'd1;
   localparam logic [1:0] ST_RESP            = 2'd2;

   // class + subclass + pw + imm + gpr_rs1 + four CPR indices
   localparam int ENTRY_W = 90;

   typedef struct packed {
      logic [2:0]  cls;
      logic [3:0]  subcls;
      logic [2:0]  pw;
      logic [31:0] imm;
      logic [31:0] gpr_rs1;
      logic [3:0]  crs1;
      logic [3:0]  crs2;
      logic [3:0]  crs3;
      logic [3:0]  crd;
   } entry_t;

endpackage

// File: rtl/scarv_cop_palu_issue_fifo.sv
// Synchronous FIFO holding decoded instructions ahead of the issue register.
// DEPTH must be a power of two so the pointers wrap naturally.
module scarv_cop_palu_issue_fifo #(
   parameter int WIDTH = 90,
   parameter int DEPTH = 2
) (
   input  logic             g_clk,
   input  logic             g_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop && !o_empty;
   // A full queue may still take a push when the head leaves in the same cycle
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge g_clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/scarv_cop_palu_issue.sv
// PALU issue stage: queues decoded XCR instructions, drives the PALU, commits its CPR
// writeback and returns one in-order response. Optional watchdog: SCARV_COP_PALU_ISSUE_WDOG_EN.
module scarv_cop_palu_issue
   import scarv_cop_palu_issue_pkg::*;
#(
   parameter int DEPTH       = 2,
   parameter int WDOG_CYCLES = 64
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [2:0]  id_class,
   input  logic [3:0]  id_subclass,
   input  logic [2:0]  id_pw,
   input  logic [31:0] id_imm,
   input  logic [31:0] id_gpr_rs1,
   input  logic [3:0]  id_crs1,
   input  logic [3:0]  id_crs2,
   input  logic [3:0]  id_crs3,
   input  logic [3:0]  id_crd,
   output logic [3:0]  cpr_rs1_addr,
   output logic [3:0]  cpr_rs2_addr,
   output logic [3:0]  cpr_rs3_addr,
   input  logic [31:0] cpr_rs1_rdata,
   input  logic [31:0] cpr_rs2_rdata,
   input  logic [31:0] cpr_rs3_rdata,
   output logic        palu_ivalid,
   input  logic        palu_idone,
   output logic [31:0] palu_gpr_rs1,
   output logic [31:0] palu_rs1,
   output logic [31:0] palu_rs2,
   output logic [31:0] palu_rs3,
   output logic [31:0] palu_imm,
   output logic [2:0]  palu_pw,
   output logic [2:0]  palu_class,
   output logic [3:0]  palu_subclass,
   input  logic [3:0]  palu_cpr_rd_ben,
   input  logic [31:0] palu_cpr_rd_wdata,
   output logic [3:0]  cpr_rd_addr,
   output logic [3:0]  cpr_rd_ben,
   output logic [31:0] cpr_rd_wdata,
   output logic        rsp_valid,
   output logic        rsp_error,
   input  logic        rsp_ready
);

   entry_t             w_in_entry;
   logic [ENTRY_W-1:0] w_fifo_out;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_exec;
   logic               w_commit;
   logic               w_timeout;
   logic [1:0]         w_state_nxt;
   logic [1:0]         r_state;
   entry_t             r_issue;

   always_comb begin
      w_in_entry         = '0;
      w_in_entry.cls     = id_class;
      w_in_entry.subcls  = id_subclass;
      w_in_entry.pw      = id_pw;
      w_in_entry.imm     = id_imm;
      w_in_entry.gpr_rs1 = id_gpr_rs1;
      w_in_entry.crs1    = id_crs1;
      w_in_entry.crs2    = id_crs2;
      w_in_entry.crs3    = id_crs3;
      w_in_entry.crd     = id_crd;
   end

   scarv_cop_palu_issue_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .i_push  (id_valid && id_ready),
      .i_data  (w_in_entry),
      .i_pop   (w_pop),
      .o_data  (w_fifo_out),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign id_ready = !w_full;
   assign w_exec   = (r_state == ST_EXEC);
   assign w_commit = w_exec && palu_idone;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_EXEC;
         end
         ST_EXEC: if (palu_idone || w_timeout) w_state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) begin
            w_pop       = !w_empty;
            w_state_nxt = w_empty ? ST_IDLE : ST_EXEC;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_state <= ST_IDLE;
         r_issue <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) r_issue <= entry_t'(w_fifo_out);
      end
   end

`ifdef SCARV_COP_PALU_ISSUE_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES) + 1;

   logic [WW-1:0] r_wdog;
   logic          r_err;

   // idone in the terminal-count cycle takes priority over the abort
   assign w_timeout = w_exec && !palu_idone && (r_wdog == WW'(WDOG_CYCLES - 1));
   assign rsp_error = (r_state == ST_RESP) && r_err;

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_pop)       r_wdog <= '0;
         else if (w_exec) r_wdog <= r_wdog + 1'b1;
         if (w_pop)          r_err <= 1'b0;
         else if (w_timeout) r_err <= 1'b1;
      end
   end
`else
   logic w_unused_wdog;

   assign w_unused_wdog = WDOG_CYCLES[0];
   assign w_timeout     = 1'b0;
   assign rsp_error     = 1'b0;
`endif

   assign cpr_rs1_addr  = r_issue.crs1;
   assign cpr_rs2_addr  = r_issue.crs2;
   assign cpr_rs3_addr  = r_issue.crs3;

   assign palu_ivalid   = w_exec;
   assign palu_gpr_rs1  = r_issue.gpr_rs1;
   assign palu_imm      = r_issue.imm;
   assign palu_pw       = r_issue.pw;
   assign palu_class    = r_issue.cls;
   assign palu_subclass = r_issue.subcls;
   // Operands are re-read each EXEC cycle; nothing else writes the CPRs meanwhile
   assign palu_rs1      = w_exec ? cpr_rs1_rdata : 32'd0;
   assign palu_rs2      = w_exec ? cpr_rs2_rdata : 32'd0;
   assign palu_rs3      = w_exec ? cpr_rs3_rdata : 32'd0;

   assign cpr_rd_ben    = w_commit ? palu_cpr_rd_ben   : 4'd0;
   assign cpr_rd_addr   = w_commit ? r_issue.crd       : 4'd0;
   assign cpr_rd_wdata  = w_commit ? palu_cpr_rd_wdata : 32'd0;

   assign rsp_valid     = (r_state == ST_RESP);

endmodule

// File: tb/tb_scarv_cop_palu_issue.sv
// Directed bench for scarv_cop_palu_issue: a small CPR file model, the PALU side driven
// cycle by cycle, and hand-computed expectations per scenario.
module tb_scarv_cop_palu_issue;
   import scarv_cop_palu_issue_pkg::*;

`ifdef SCARV_COP_PALU_ISSUE_WDOG_EN
   localparam int TB_WDOG = 4;
`else
   localparam int TB_WDOG = 64;
`endif

   logic        g_clk, g_reset;
   logic        id_valid, id_ready;
   logic [2:0]  id_class, id_pw;
   logic [3:0]  id_subclass, id_crs1, id_crs2, id_crs3, id_crd;
   logic [31:0] id_imm, id_gpr_rs1;
   logic [3:0]  cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr;
   logic [31:0] cpr_rs1_rdata, cpr_rs2_rdata, cpr_rs3_rdata;
   logic        palu_ivalid, palu_idone;
   logic [31:0] palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3, palu_imm;
   logic [2:0]  palu_pw, palu_class;
   logic [3:0]  palu_subclass, palu_cpr_rd_ben;
   logic [31:0] palu_cpr_rd_wdata;
   logic [3:0]  cpr_rd_addr, cpr_rd_ben;
   logic [31:0] cpr_rd_wdata;
   logic        rsp_valid, rsp_error, rsp_ready;

   logic [31:0] cpr [16];
   logic        tb_wr_en;
   logic [3:0]  tb_wr_addr;
   logic [31:0] tb_wr_data;
   int          wr_cnt, rsp_cnt;
   int          checks, errors;

   scarv_cop_palu_issue #(.DEPTH(2), .WDOG_CYCLES(TB_WDOG)) dut (
      .g_clk(g_clk), .g_reset(g_reset),
      .id_valid(id_valid), .id_ready(id_ready), .id_class(id_class), .id_subclass(id_subclass),
      .id_pw(id_pw), .id_imm(id_imm), .id_gpr_rs1(id_gpr_rs1),
      .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3), .id_crd(id_crd),
      .cpr_rs1_addr(cpr_rs1_addr), .cpr_rs2_addr(cpr_rs2_addr), .cpr_rs3_addr(cpr_rs3_addr),
      .cpr_rs1_rdata(cpr_rs1_rdata), .cpr_rs2_rdata(cpr_rs2_rdata), .cpr_rs3_rdata(cpr_rs3_rdata),
      .palu_ivalid(palu_ivalid), .palu_idone(palu_idone),
      .palu_gpr_rs1(palu_gpr_rs1), .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
      .palu_imm(palu_imm), .palu_pw(palu_pw), .palu_class(palu_class), .palu_subclass(palu_subclass),
      .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
      .cpr_rd_addr(cpr_rd_addr), .cpr_rd_ben(cpr_rd_ben), .cpr_rd_wdata(cpr_rd_wdata),
      .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_ready(rsp_ready)
   );

   initial begin
      g_clk = 1'b0;
      forever #5 g_clk = ~g_clk;
   end

   assign cpr_rs1_rdata = cpr[cpr_rs1_addr];
   assign cpr_rs2_rdata = cpr[cpr_rs2_addr];
   assign cpr_rs3_rdata = cpr[cpr_rs3_addr];

   // CPR file plus writeback and response counters
   always @(posedge g_clk) begin
      if (tb_wr_en) cpr[tb_wr_addr] <= tb_wr_data;
      for (int b = 0; b < 4; b++)
         if (cpr_rd_ben[b]) cpr[cpr_rd_addr][8*b +: 8] <= cpr_rd_wdata[8*b +: 8];
      if (cpr_rd_ben != 4'd0) wr_cnt <= wr_cnt + 1;
      if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
   end

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] a, input logic [31:0] d);
      tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = d;
      step();
      tb_wr_en = 1'b0;
   endtask

   task automatic drive_id(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                           input logic [3:0] rd, input logic [2:0] cl, input logic [3:0] sc,
                           input logic [2:0] pw);
      id_valid = 1'b1; id_crs1 = c1; id_crs2 = c2; id_crs3 = c3; id_crd = rd;
      id_class = cl; id_subclass = sc; id_pw = pw;
      id_imm = {28'hC0DE000, rd}; id_gpr_rs1 = 32'h1000_0000;
   endtask

   task automatic palu_drive(input logic d, input logic [3:0] ben, input logic [31:0] wd);
      palu_idone = d; palu_cpr_rd_ben = ben; palu_cpr_rd_wdata = wd;
   endtask

   task automatic test_reset();
      g_reset = 1'b1;
      step(); step();
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %b exp 1", id_ready); end
      checks++; if (palu_ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid got %b exp 0", palu_ivalid); end
      checks++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b%b exp 00", rsp_valid, rsp_error); end
      checks++; if (cpr_rd_ben !== 4'h0 || cpr_rd_wdata !== 32'h0) begin errors++; $display("FAIL reset_wb got %h/%h exp 0/0", cpr_rd_ben, cpr_rd_wdata); end
      checks++; if (palu_rs1 !== 32'h0 || palu_class !== 3'h0 || cpr_rs1_addr !== 4'h0) begin errors++; $display("FAIL reset_palu got %h/%h/%h exp 0", palu_rs1, palu_class, cpr_rs1_addr); end
      g_reset = 1'b0;
      step();
   endtask

   task automatic test_add();
      int w0, r0;
      w0 = wr_cnt; r0 = rsp_cnt;
      drive_id(4'd1, 4'd2, 4'd0, 4'd4, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      step();
      id_valid = 1'b0;
      checks++; if (palu_ivalid !== 1'b0) begin errors++; $display("FAIL add_idle_ivalid got %b exp 0", palu_ivalid); end
      step();
      checks++; if (palu_ivalid !== 1'b1) begin errors++; $display("FAIL add_ivalid got %b exp 1", palu_ivalid); end
      checks++; if (palu_rs1 !== 32'd5 || palu_rs2 !== 32'd7) begin errors++; $display("FAIL add_operands got %0d,%0d exp 5,7", palu_rs1, palu_rs2); end
      checks++; if (palu_class !== CLASS_PACKED_ARITH || palu_imm !== 32'hC0DE0004) begin errors++; $display("FAIL add_fields got %h/%h exp %h/C0DE0004", palu_class, palu_imm, CLASS_PACKED_ARITH); end
      checks++; if (cpr_rd_ben !== 4'h0) begin errors++; $display("FAIL add_ben_pre got %h exp 0", cpr_rd_ben); end
      palu_drive(1'b1, 4'hF, 32'd12);
      #1;
      checks++; if (cpr_rd_ben !== 4'hF || cpr_rd_addr !== 4'd4 || cpr_rd_wdata !== 32'd12) begin errors++; $display("FAIL add_wb got %h@%h=%0d exp F@4=12", cpr_rd_ben, cpr_rd_addr, cpr_rd_wdata); end
      step();
      palu_drive(1'b0, 4'h0, 32'h0);
      checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || palu_ivalid !== 1'b0) begin errors++; $display("FAIL add_resp got v%b e%b iv%b exp 1,0,0", rsp_valid, rsp_error, palu_ivalid); end
      checks++; if (cpr[4] !== 32'd12) begin errors++; $display("FAIL add_cpr got %0d exp 12", cpr[4]); end
      step();
      checks++; if (rsp_valid !== 1'b0 || rsp_cnt - r0 != 1 || wr_cnt - w0 != 1) begin errors++; $display("FAIL add_counts got v%b rsp%0d wr%0d exp 0,1,1", rsp_valid, rsp_cnt - r0, wr_cnt - w0); end
   endtask

   task automatic test_back_to_back();
      int r0;
      preload(4'd3, 32'h0);
      preload(4'd6, 32'h0);
      r0 = rsp_cnt;
      drive_id(4'd1, 4'd2, 4'd0, 4'd3, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      step();
      drive_id(4'd3, 4'd2, 4'd0, 4'd6, CLASS_PACKED_ARITH, SUBCLASS_PSUB, PW_32);
      step();
      id_valid = 1'b0;
      checks++; if (palu_ivalid !== 1'b1 || palu_rs1 !== 32'd5) begin errors++; $display("FAIL b2b_a_issue got iv%b rs1=%h exp 1,5", palu_ivalid, palu_rs1); end
      palu_drive(1'b1, 4'hF, 32'h10);
      step();
      palu_drive(1'b0, 4'h0, 32'h0);
      checks++; if (rsp_valid !== 1'b1 || cpr[3] !== 32'h10 || cpr[6] !== 32'h0) begin errors++; $display("FAIL b2b_a_resp got v%b c3=%h c6=%h exp 1,10,0", rsp_valid, cpr[3], cpr[6]); end
      step();
      checks++; if (palu_ivalid !== 1'b1 || cpr_rs1_addr !== 4'd3 || palu_rs1 !== 32'h10) begin errors++; $display("FAIL b2b_b_rs1 got iv%b a%h rs1=%h exp 1,3,10", palu_ivalid, cpr_rs1_addr, palu_rs1); end
      palu_drive(1'b1, 4'hF, 32'h22);
      step();
      palu_drive(1'b0, 4'h0, 32'h0);
      checks++; if (rsp_valid !== 1'b1 || cpr[6] !== 32'h22) begin errors++; $display("FAIL b2b_b_resp got v%b c6=%h exp 1,22", rsp_valid, cpr[6]); end
      step();
      checks++; if (rsp_valid !== 1'b0 || rsp_cnt - r0 != 2) begin errors++; $display("FAIL b2b_count got v%b n%0d exp 0,2", rsp_valid, rsp_cnt - r0); end
   endtask

   task automatic test_mul();
      int w0, r0, nvalid, bad;
      w0 = wr_cnt; r0 = rsp_cnt; nvalid = 0; bad = 0;
      drive_id(4'd1, 4'd2, 4'd0, 4'd7, CLASS_PACKED_ARITH, SUBCLASS_PMUL, PW_16);
      step();
      id_valid = 1'b0;
      step();
      for (int i = 0; i < 9; i++) begin
         if (palu_ivalid === 1'b1) nvalid++;
         if (palu_rs1 !== 32'd5 || palu_rs2 !== 32'd7 || cpr_rd_ben !== 4'h0) bad++;
         if (i == 8) palu_drive(1'b1, 4'hF, 32'd35);
         step();
      end
      palu_drive(1'b0, 4'h0, 32'h0);
      checks++; if (nvalid != 9) begin errors++; $display("FAIL mul_ivalid_cycles got %0d exp 9", nvalid); end
      checks++; if (bad != 0) begin errors++; $display("FAIL mul_operands_stable got %0d bad exp 0", bad); end
      checks++; if (rsp_valid !== 1'b1 || palu_ivalid !== 1'b0 || cpr[7] !== 32'd35) begin errors++; $display("FAIL mul_resp got v%b iv%b c7=%0d exp 1,0,35", rsp_valid, palu_ivalid, cpr[7]); end
      step();
      checks++; if (wr_cnt - w0 != 1 || rsp_cnt - r0 != 1) begin errors++; $display("FAIL mul_counts got wr%0d rsp%0d exp 1,1", wr_cnt - w0, rsp_cnt - r0); end
   endtask

   task automatic test_fill();
      int w0, r0;
      bit done;
      preload(4'd12, 32'h0);
      w0 = wr_cnt; r0 = rsp_cnt; done = 1'b0;
      rsp_ready = 1'b0;
      drive_id(4'd1, 4'd0, 4'd0, 4'd9, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      step();
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL fill_ready1 got %b exp 1", id_ready); end
      drive_id(4'd2, 4'd0, 4'd0, 4'd10, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      step();
      checks++; if (id_ready !== 1'b1 || palu_ivalid !== 1'b1) begin errors++; $display("FAIL fill_ready2 got r%b iv%b exp 1,1", id_ready, palu_ivalid); end
      palu_drive(1'b1, 4'hF, 32'hA1);
      drive_id(4'd3, 4'd0, 4'd0, 4'd11, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      step();
      palu_drive(1'b0, 4'h0, 32'h0);
      drive_id(4'd4, 4'd0, 4'd0, 4'd12, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      checks++; if (id_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL fill_full got r%b v%b exp 0,1", id_ready, rsp_valid); end
      step(); step();
      checks++; if (id_ready !== 1'b0 || rsp_valid !== 1'b1 || palu_ivalid !== 1'b0) begin errors++; $display("FAIL fill_hold got r%b v%b iv%b exp 0,1,0", id_ready, rsp_valid, palu_ivalid); end
      id_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         if (palu_ivalid === 1'b1) palu_drive(1'b1, 4'hF, {24'h0, 4'hA, cpr_rs1_addr});
         else palu_drive(1'b0, 4'h0, 32'h0);
         step();
         done = (rsp_cnt - r0 >= 3) && !rsp_valid && !palu_ivalid;
      end
      palu_drive(1'b0, 4'h0, 32'h0);
      checks++; if (!done) begin errors++; $display("FAIL fill_drain_timeout got rsp%0d exp 3 within 20 cycles", rsp_cnt - r0); end
      checks++; if (rsp_cnt - r0 != 3 || wr_cnt - w0 != 3) begin errors++; $display("FAIL fill_counts got rsp%0d wr%0d exp 3,3", rsp_cnt - r0, wr_cnt - w0); end
      checks++; if (cpr[9] !== 32'hA1 || cpr[10] !== 32'hA2 || cpr[11] !== 32'hA3 || cpr[12] !== 32'h0) begin errors++; $display("FAIL fill_data got %h %h %h %h exp A1 A2 A3 0", cpr[9], cpr[10], cpr[11], cpr[12]); end
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_end got %b exp 1", id_ready); end
   endtask

   task automatic test_cmov();
      int w0, r0;
      preload(4'd13, 32'h55);
      w0 = wr_cnt; r0 = rsp_cnt;
      drive_id(4'd1, 4'd2, 4'd3, 4'd13, CLASS_CMOV, SUBCLASS_CMOV_T, PW_32);
      step();
      id_valid = 1'b0;
      step();
      palu_drive(1'b1, 4'h0, 32'hDEAD);
      #1;
      checks++; if (palu_ivalid !== 1'b1 || cpr_rd_ben !== 4'h0) begin errors++; $display("FAIL cmov_ben got iv%b ben%h exp 1,0", palu_ivalid, cpr_rd_ben); end
      step();
      palu_drive(1'b0, 4'h0, 32'h0);
      checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || cpr_rd_ben !== 4'h0) begin errors++; $display("FAIL cmov_resp got v%b e%b ben%h exp 1,0,0", rsp_valid, rsp_error, cpr_rd_ben); end
      step();
      checks++; if (cpr[13] !== 32'h55 || wr_cnt - w0 != 0 || rsp_cnt - r0 != 1) begin errors++; $display("FAIL cmov_counts got c13=%h wr%0d rsp%0d exp 55,0,1", cpr[13], wr_cnt - w0, rsp_cnt - r0); end
   endtask

`ifdef SCARV_COP_PALU_ISSUE_WDOG_EN
   task automatic test_wdog();
      int w0, r0, nvalid;
      preload(4'd14, 32'h66);
      w0 = wr_cnt; r0 = rsp_cnt; nvalid = 0;
      drive_id(4'd1, 4'd2, 4'd0, 4'd14, CLASS_PACKED_ARITH, SUBCLASS_PMUL, PW_32);
      step();
      id_valid = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         if (palu_ivalid === 1'b1) nvalid++;
         step();
      end
      checks++; if (nvalid != 4) begin errors++; $display("FAIL wdog_ivalid_cycles got %0d exp 4", nvalid); end
      checks++; if (palu_ivalid !== 1'b0 || rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin errors++; $display("FAIL wdog_resp got iv%b v%b e%b exp 0,1,1", palu_ivalid, rsp_valid, rsp_error); end
      step();
      checks++; if (wr_cnt - w0 != 0 || rsp_cnt - r0 != 1 || cpr[14] !== 32'h66) begin errors++; $display("FAIL wdog_counts got wr%0d rsp%0d c14=%h exp 0,1,66", wr_cnt - w0, rsp_cnt - r0, cpr[14]); end
   endtask
`endif

   task automatic test_reset_mid_exec();
      int w0, r0;
      preload(4'd15, 32'h77);
      w0 = wr_cnt; r0 = rsp_cnt;
      drive_id(4'd1, 4'd2, 4'd0, 4'd15, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      step();
      drive_id(4'd2, 4'd1, 4'd0, 4'd15, CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32);
      step();
      id_valid = 1'b0;
      palu_drive(1'b1, 4'hF, 32'hBAD);
      g_reset = 1'b1;
      #1;
      checks++; if (palu_ivalid !== 1'b0 || rsp_valid !== 1'b0 || id_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_ctrl got iv%b v%b r%b exp 0,0,1", palu_ivalid, rsp_valid, id_ready); end
      checks++; if (cpr_rd_ben !== 4'h0 || palu_rs1 !== 32'h0 || cpr_rs1_addr !== 4'h0) begin errors++; $display("FAIL rst_exec_data got ben%h rs1=%h a%h exp 0", cpr_rd_ben, palu_rs1, cpr_rs1_addr); end
      step();
      g_reset = 1'b0;
      palu_drive(1'b0, 4'h0, 32'h0);
      step(); step();
      checks++; if (palu_ivalid !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_flush got iv%b v%b exp 0,0", palu_ivalid, rsp_valid); end
      checks++; if (cpr[15] !== 32'h77 || wr_cnt - w0 != 0 || rsp_cnt - r0 != 0) begin errors++; $display("FAIL rst_exec_counts got c15=%h wr%0d rsp%0d exp 77,0,0", cpr[15], wr_cnt - w0, rsp_cnt - r0); end
   endtask

   initial begin
      checks = 0; errors = 0; wr_cnt = 0; rsp_cnt = 0;
      g_reset = 1'b1; id_valid = 1'b0; rsp_ready = 1'b1;
      id_class = 3'd0; id_subclass = 4'd0; id_pw = 3'd0; id_imm = 32'd0; id_gpr_rs1 = 32'd0;
      id_crs1 = 4'd0; id_crs2 = 4'd0; id_crs3 = 4'd0; id_crd = 4'd0;
      tb_wr_en = 1'b0; tb_wr_addr = 4'd0; tb_wr_data = 32'd0;
      palu_drive(1'b0, 4'h0, 32'h0);
      test_reset();
      preload(4'd0, 32'h0);
      preload(4'd1, 32'd5);
      preload(4'd2, 32'd7);
      test_add();
      test_back_to_back();
`ifndef SCARV_COP_PALU_ISSUE_WDOG_EN
      test_mul();
`endif
      test_fill();
      test_cmov();
`ifdef SCARV_COP_PALU_ISSUE_WDOG_EN
      test_wdog();
`endif
      test_reset_mid_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
